// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: command codes,
// arbiter states, port ids and default bus widths.
package mem_bus_arbiter_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    M_NONE  = 2'b00,
    M_READ  = 2'b01,
    M_WRITE = 2'b10,
    M_ILL   = 2'b11
  } mem_cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic logic is_req(logic [1:0] cmd);
    return (cmd == M_READ) || (cmd == M_WRITE);
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, RAM and status signals of the arbiter.
// slave = arbiter view, master = environment view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = mem_bus_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_bus_arbiter_pkg::DEF_DATA_W
);
  logic [1:0]        cpu_mem_cmd;
  logic [ADDR_W-1:0] cpu_mem_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [1:0]        dma_mem_cmd;
  logic [ADDR_W-1:0] dma_mem_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  cpu_mem_cmd, cpu_mem_addr, cpu_wdata,
    input  dma_mem_cmd, dma_mem_addr, dma_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_read, ram_write, ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output cpu_mem_cmd, cpu_mem_addr, cpu_wdata,
    output dma_mem_cmd, dma_mem_addr, dma_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_read, ram_write, ram_addr, ram_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Combinational 2-way picker: req[0]=CPU, req[1]=DMA.
// Ties go to CPU in priority mode, else to the port that did not win last.
module mem_bus_arbiter_arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       cpu_priority,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    unique case (1'b1)
      (req == 2'b11):
        winner = cpu_priority ? PORT_CPU : ~last_owner;
      (req == 2'b10):
        winner = PORT_DMA;
      default:
        winner = PORT_CPU;
    endcase
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port RAM between CPU and DMA requesters,
// one access outstanding, read data returned to the winning port.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter bit CPU_PRIORITY = 1'b0
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);
  arb_state_e        state;
  logic              owner;
  logic              last_owner;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              cpu_gnt_q;
  logic              dma_gnt_q;
  logic              cpu_rv_q;
  logic              dma_rv_q;
  logic              rd_q;
  logic              wr_q;

  logic [1:0] req;
  logic       pick;
  logic       winner;
  logic [1:0] win_cmd;

  assign req = {is_req(bus.dma_mem_cmd),
                is_req(bus.cpu_mem_cmd)};
  assign win_cmd = winner ? bus.dma_mem_cmd
                          : bus.cpu_mem_cmd;

  mem_bus_arbiter_arb_rr2 u_pick (
    .req          (req),
    .last_owner   (last_owner),
    .cpu_priority (CPU_PRIORITY),
    .valid        (pick),
    .winner       (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= PORT_CPU;
      last_owner  <= PORT_DMA;
      op_wr       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_rv_q    <= 1'b0;
      dma_rv_q    <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      cpu_gnt_q <= 1'b0;
      dma_gnt_q <= 1'b0;
      cpu_rv_q  <= 1'b0;
      dma_rv_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick) begin
            state     <= ACCESS;
            owner     <= winner;
            op_wr     <= (win_cmd == M_WRITE);
            addr_q    <= winner ? bus.dma_mem_addr
                                : bus.cpu_mem_addr;
            wdata_q   <= winner ? bus.dma_wdata
                                : bus.cpu_wdata;
            cpu_gnt_q <= (winner == PORT_CPU);
            dma_gnt_q <= (winner == PORT_DMA);
            rd_q      <= (win_cmd != M_WRITE);
            wr_q      <= (win_cmd == M_WRITE);
          end
        end
        ACCESS: begin
          last_owner <= owner;
          state      <= op_wr ? IDLE : RESP;
        end
        RESP: begin
          state <= IDLE;
          // rvalid pulses in the IDLE cycle that follows
          if (owner == PORT_CPU) begin
            cpu_rdata_q <= bus.ram_rdata;
            cpu_rv_q    <= 1'b1;
          end else begin
            dma_rdata_q <= bus.ram_rdata;
            dma_rv_q    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.dma_gnt    = dma_gnt_q;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.dma_rvalid = dma_rv_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.ram_read   = rd_q;
  assign bus.ram_write  = wr_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.busy       = (state != IDLE);
endmodule
